demux_lane_split: RTL and testbench
===================================

# demux_lane_split

Receive-side counterpart of the two-lane 8-bit mux. It takes the single interleaved word stream (lane 0 word first, then lane 1 word) on one clock and splits it back into two lanes. Each re-assembled pair is presented on both lane outputs in the same cycle. A lane-0 word left without its partner is flushed alone after a bounded idle time. The block sits at the receive end of the mux link, ahead of per-lane consumers.

## Interface
- WIDTH, 8, word width of stream and lanes
- TIMEOUT, 4, consecutive idle cycles (no `valid_in`) tolerated while a lane-0 word is pending; range 1..15

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- data_in  input  WIDTH  interleaved stream word
- valid_in  input  1  `data_in` carries a word this cycle
- data_out_0  output  WIDTH  lane 0 word
- valid_out_0  output  1  `data_out_0` valid (one-cycle pulse)
- data_out_1  output  WIDTH  lane 1 word
- valid_out_1  output  1  `data_out_1` valid (one-cycle pulse)
- orphan  output  1  pulses with a lane-0-only flush

## Operation
- Reset values (asserted, asynchronous):
  - state IDLE; idle counter 0; holding register 0.
  - `data_out_0` = 0, `data_out_1` = 0, `valid_out_0` = 0, `valid_out_1` = 0, `orphan` = 0.
- State IDLE (no pending word):
  - `valid_in`=1: capture `data_in` into the lane-0 holding register, clear the idle counter, go to HALF.
  - `valid_in`=0: stay in IDLE.
- State HALF (lane-0 word held):
  - `valid_in`=1: pair complete.
    - `data_out_0` <= holding register; `data_out_1` <= `data_in`.
    - `valid_out_0` = `valid_out_1` = 1; `orphan` = 0.
    - Go to IDLE; clear the counter.
  - `valid_in`=0 and counter+1 < TIMEOUT: increment the counter and stay in HALF.
  - `valid_in`=0 and counter+1 == TIMEOUT: flush.
    - `data_out_0` <= holding register; `valid_out_0` = 1.
    - `valid_out_1` = 0; `orphan` = 1.
    - `data_out_1` unchanged; go to IDLE; clear the counter.
- `valid_in` always wins over timeout on the same edge: a word arriving on the would-be flush edge completes the pair.
- Lane assignment toggles only on valid words (and on flush). Idle gaps shorter than TIMEOUT between the halves of a pair are transparent.
- Idle counter width is 4 bits, unsigned. It never wraps, because the flush clears it at TIMEOUT.
- All valid/orphan outputs are registered pulses, high for exactly one cycle per event.
- Data outputs hold their last value when their valid is low. They change only on the events above.
- Reset mid-pair discards the held lane-0 word without flushing it. The first valid word after reset release is lane 0.

## Timing
- Pair latency: lane-1 word sampled at edge N; both valids high in cycle N..N+1 (registered, 1 cycle after the lane-1 word).
- Back-to-back throughput: with `valid_in` continuously high, one pair is emitted every 2 cycles. There are no bubbles or stalls, and no backpressure.
- Flush timing (lane-0 word sampled at edge N, then idle):
  - `valid_out_0` and `orphan` go high after edge N+TIMEOUT.
  - A new word at edge N+TIMEOUT+1 starts a fresh pair as lane 0.
- Reset deassertion: the first edge with `reset`=0 may sample `valid_in`.
- Outputs are never combinationally dependent on inputs.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> all outputs 0 immediately; state IDLE.
- Continuous pairs: `valid_in`=1 with words 0x11, 0x22, 0x33, 0x44 on consecutive edges -> cycle after 0x22: out0=0x11, out1=0x22, both valid. Two cycles later: out0=0x33, out1=0x44. `orphan` stays 0.
- Gapped pair: 0xA5, then 3 idle cycles, then 0x5A, with TIMEOUT=4 -> single pair out0=0xA5, out1=0x5A; no flush.
- Timeout flush: 0xC3, then 4 idle cycles -> after the 4th idle edge: `valid_out_0`=1, out0=0xC3, `valid_out_1`=0, `orphan`=1. The next word 0x77 is treated as lane 0.
- Boundary race: 0x10, then 3 idle cycles, then 0x20 on the 4th edge -> pair (0x10, 0x20) emitted; `orphan`=0.
- Reset mid-pair: 0xEE sampled, `reset` pulsed, then 0x01, 0x02 -> no output for 0xEE; pair (0x01, 0x02) emitted.

Source files
------------

// File: rtl/demux_lane_split.sv
// demux_lane_split: splits an interleaved two-lane word stream back into lanes.
// Words arrive as lane 0, then lane 1. A complete pair is presented on both
// lane outputs in the same cycle. A lane-0 word whose partner does not arrive
// within TIMEOUT idle cycles is flushed on its own, and orphan pulses with it.
module demux_lane_split #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 4   // legal range 1..15, fits the 4-bit idle counter
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] data_out_0,
  output logic             valid_out_0,
  output logic [WIDTH-1:0] data_out_1,
  output logic             valid_out_1,
  output logic             orphan
);

  typedef enum logic {IDLE, HALF} state_t;

  state_t           state_q;
  logic [3:0]       cnt_q;    // idle cycles seen while a lane-0 word is held
  logic [WIDTH-1:0] hold_q;   // pending lane-0 word
  logic [WIDTH-1:0] d0_q, d1_q;
  logic             v0_q, v1_q, orph_q;

  // One bit wider than the counter so the compare with TIMEOUT cannot wrap.
  logic [4:0] cnt_inc;
  logic       tmo_hit;

  // Next idle count and the flush condition for the held word.
  always_comb begin
    cnt_inc = {1'b0, cnt_q} + 5'd1;
    tmo_hit = (cnt_inc == 5'(TIMEOUT));
  end

  // Pairing FSM with registered outputs; valid_in always beats the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      orph_q  <= 1'b0;
    end else begin
      // Valid/orphan outputs are single-cycle pulses.
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      orph_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            hold_q  <= data_in;
            cnt_q   <= '0;
            state_q <= HALF;
          end
        end
        HALF: begin
          if (valid_in) begin
            d0_q    <= hold_q;
            d1_q    <= data_in;
            v0_q    <= 1'b1;
            v1_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (tmo_hit) begin
            // Partner never came: emit lane 0 alone, lane-1 data untouched.
            d0_q    <= hold_q;
            v0_q    <= 1'b1;
            orph_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q   <= cnt_inc[3:0];
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign data_out_0  = d0_q;
  assign data_out_1  = d1_q;
  assign valid_out_0 = v0_q;
  assign valid_out_1 = v1_q;
  assign orphan      = orph_q;

endmodule

// File: tb/tb_demux_lane_split.sv
// Bench for demux_lane_split: directed scenarios followed by random word/gap
// traffic, compared every cycle against a timestamp-based pairing model.
module tb_demux_lane_split;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic [WIDTH-1:0] data_out_0, data_out_1;
  logic             valid_out_0, valid_out_1, orphan;

  demux_lane_split #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .data_out_0(data_out_0), .valid_out_0(valid_out_0),
    .data_out_1(data_out_1), .valid_out_1(valid_out_1), .orphan(orphan)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a pending lane-0 word remembers the edge it was taken on;
  // it is flushed when exactly TIMEOUT edges have passed without a new word.
  bit               pend;
  logic [WIDTH-1:0] pend_d;
  int               pend_cyc;
  logic [WIDTH-1:0] e_d0, e_d1;
  bit               e_v0, e_v1, e_or;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".v0"},  {31'd0, valid_out_0}, {31'd0, e_v0});
    chk({tag, ".v1"},  {31'd0, valid_out_1}, {31'd0, e_v1});
    chk({tag, ".orp"}, {31'd0, orphan},      {31'd0, e_or});
    chk({tag, ".d0"},  {24'd0, data_out_0},  {24'd0, e_d0});
    chk({tag, ".d1"},  {24'd0, data_out_1},  {24'd0, e_d1});
  endtask

  task automatic model_clear();
    pend = 0; pend_d = '0; pend_cyc = 0;
    e_d0 = '0; e_d1 = '0; e_v0 = 0; e_v1 = 0; e_or = 0;
  endtask

  // Drive one cycle of input, advance past the edge, update model, compare.
  task automatic step(input bit v, input logic [WIDTH-1:0] d);
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    #1;
    e_v0 = 0; e_v1 = 0; e_or = 0;
    if (v) begin
      if (pend) begin
        e_d0 = pend_d; e_d1 = d; e_v0 = 1; e_v1 = 1; pend = 0;
      end else begin
        pend = 1; pend_d = d; pend_cyc = cyc;
      end
    end else if (pend && (cyc - pend_cyc) == TIMEOUT) begin
      e_d0 = pend_d; e_v0 = 1; e_or = 1; pend = 0;
    end
    check_all("step");
  endtask

  // Asynchronous reset pulse in the middle of a cycle.
  task automatic async_reset();
    #2;
    reset    = 1'b1;
    valid_in = 1'b0;
    #1;
    model_clear();
    check_all("async_rst");
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = '0;
    model_clear();
    #12;
    check_all("reset_state");
    #1 reset = 1'b0;

    // Continuous pairs
    step(1, 8'h11);
    step(1, 8'h22);
    chk("cont.p0.d0", {24'd0, data_out_0}, 32'h11);
    chk("cont.p0.d1", {24'd0, data_out_1}, 32'h22);
    step(1, 8'h33);
    chk("cont.gap.v0", {31'd0, valid_out_0}, 32'd0);
    step(1, 8'h44);
    chk("cont.p1.d0", {24'd0, data_out_0}, 32'h33);
    chk("cont.p1.d1", {24'd0, data_out_1}, 32'h44);

    // Async reset while outputs are nonzero
    async_reset();
    chk("rst.d0", {24'd0, data_out_0}, 32'd0);

    // Gapped pair, gap shorter than TIMEOUT
    step(1, 8'hA5);
    repeat (3) step(0, 8'h00);
    step(1, 8'h5A);
    chk("gap.d1",  {24'd0, data_out_1}, 32'h5A);
    chk("gap.orp", {31'd0, orphan}, 32'd0);

    // Timeout flush, then the next word is lane 0 again
    step(1, 8'hC3);
    repeat (3) step(0, 8'h00);
    step(0, 8'h00);
    chk("flush.orp", {31'd0, orphan}, 32'd1);
    chk("flush.d0",  {24'd0, data_out_0}, 32'hC3);
    chk("flush.v1",  {31'd0, valid_out_1}, 32'd0);
    chk("flush.d1",  {24'd0, data_out_1}, 32'h5A);
    step(1, 8'h77);
    step(1, 8'h88);
    chk("after_flush.d0", {24'd0, data_out_0}, 32'h77);

    // Boundary race: word arrives on the would-be flush edge
    step(1, 8'h10);
    repeat (3) step(0, 8'h00);
    step(1, 8'h20);
    chk("race.v1",  {31'd0, valid_out_1}, 32'd1);
    chk("race.orp", {31'd0, orphan}, 32'd0);

    // Reset mid-pair discards the held word
    step(1, 8'hEE);
    async_reset();
    step(1, 8'h01);
    chk("rstmid.v0", {31'd0, valid_out_0}, 32'd0);
    step(1, 8'h02);
    chk("rstmid.d0", {24'd0, data_out_0}, 32'h01);
    chk("rstmid.d1", {24'd0, data_out_1}, 32'h02);

    // Random words separated by random gaps around the timeout
    for (int i = 0; i < 400; i++) begin
      step(1, 8'($urandom));
      repeat ($urandom_range(0, TIMEOUT + 2)) step(0, 8'($urandom));
      if ($urandom_range(0, 49) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
